// File: rtl/moving_average_multichannel.sv
// moving_average_multichannel
//
// Time-multiplexed moving-average filter. Each of Channels independent
// channels keeps its own circular sample buffer (2^MaxExponent deep), write
// pointer, fill count and running-sum accumulator. A sample arriving on
// channel c updates only channel c's state. The result is available one
// cycle later: the running sum of the last N = 2^e samples, divided by N.
// Before N samples have arrived, missing samples count as zero.
//
// Build option:
//   MOVING_AVERAGE_ROUNDING_EN  defined   -> d_out = (sum + N/2) >> e
//                               undefined -> d_out = sum >> e (floor)
//
// Ports:
//   clk          single clock, rising edge
//   reset        asynchronous active-high reset
//   flush        synchronous clear of every channel's accumulator/pointer/fill
//   win_exp      runtime window exponent e (clamped to MaxExponent)
//   in_valid     sample strobe
//   in_channel   channel of d_in (values >= Channels are ignored)
//   d_in         sample
//   out_valid    result strobe, exactly one cycle after an accepted sample
//   out_channel  channel of d_out
//   d_out        window average
//   out_primed   window already held N samples when d_out was computed
//
// Handshake: in_valid and out_valid are plain one-cycle strobes with no
// back-pressure. Every accepted sample (in_valid=1, in_channel < Channels,
// no flush in that cycle) yields exactly one out_valid pulse on the next
// rising edge; out_valid is low in every other cycle.

module moving_average_multichannel #(
  parameter int MaxExponent = 4,
  parameter int DataWidth   = 16,
  parameter int Channels    = 4,
  parameter int Signed      = 0,
  localparam int ExpW = $clog2(MaxExponent + 1),
  localparam int ChW  = (Channels > 1) ? $clog2(Channels) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flush,
  input  logic [ExpW-1:0]      win_exp,
  input  logic                 in_valid,
  input  logic [ChW-1:0]       in_channel,
  input  logic [DataWidth-1:0] d_in,
  output logic                 out_valid,
  output logic [ChW-1:0]       out_channel,
  output logic [DataWidth-1:0] d_out,
  output logic                 out_primed
);

  localparam int Depth = 1 << MaxExponent;
  localparam int PtrW  = MaxExponent;
  localparam int AccW  = DataWidth + MaxExponent;
  localparam int FillW = MaxExponent + 1;

  // Per-channel state
  logic [DataWidth-1:0] buf_q  [Channels][Depth];
  logic [AccW-1:0]      acc_q  [Channels];
  logic [PtrW-1:0]      ptr_q  [Channels];
  logic [FillW-1:0]     fill_q [Channels];
  logic [ExpW-1:0]      win_exp_q;

  // Output registers
  logic                 out_valid_q;
  logic [ChW-1:0]       out_channel_q;
  logic [DataWidth-1:0] d_out_q;
  logic                 out_primed_q;

  // Combinational next-state for the addressed channel
  logic [ExpW-1:0]      e_eff;
  logic [FillW-1:0]     n_val;
  logic                 ch_ok;
  logic                 flush_eff;
  logic                 take;
  logic [ChW-1:0]       idx;
  logic [PtrW-1:0]      old_ptr;
  logic [DataWidth-1:0] old_smp;
  logic [AccW-1:0]      acc_d;
  logic [FillW-1:0]     fill_d;
  logic [AccW-1:0]      acc_rnd;
  logic [DataWidth-1:0] d_out_d;

  function automatic logic [AccW-1:0] ext(input logic [DataWidth-1:0] v);
    if (Signed != 0) begin
      return {{MaxExponent{v[DataWidth-1]}}, v};
    end
    return {{MaxExponent{1'b0}}, v};
  endfunction

  always_comb begin
    e_eff     = (32'(win_exp) > MaxExponent) ? ExpW'(MaxExponent) : win_exp;
    n_val     = FillW'(1) << e_eff;
    ch_ok     = 32'(in_channel) < Channels;
    // A new window size invalidates every running sum, so it behaves as flush.
    flush_eff = flush || (win_exp != win_exp_q);
    take      = in_valid && ch_ok && !flush_eff;
    idx       = ch_ok ? in_channel : '0;

    // The sample leaving the window sits N slots behind the write pointer.
    // When N = Depth this is the slot about to be overwritten, read first.
    old_ptr   = ptr_q[idx] - n_val[PtrW-1:0];
    old_smp   = (fill_q[idx] >= n_val) ? buf_q[idx][old_ptr] : '0;
    acc_d     = acc_q[idx] + ext(d_in) - ext(old_smp);
    fill_d    = (fill_q[idx] >= n_val) ? n_val : fill_q[idx] + FillW'(1);

`ifdef MOVING_AVERAGE_ROUNDING_EN
    acc_rnd   = (e_eff != '0) ? acc_d + (AccW'(1) << (e_eff - ExpW'(1))) : acc_d;
`else
    acc_rnd   = acc_d;
`endif

    if (Signed != 0) begin
      d_out_d = DataWidth'($signed(acc_rnd) >>> e_eff);
    end else begin
      d_out_d = DataWidth'(acc_rnd >> e_eff);
    end
  end

  // Sample storage needs no reset: the fill count gates every read.
  always_ff @(posedge clk) begin
    if (take) begin
      buf_q[idx][ptr_q[idx]] <= d_in;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int c = 0; c < Channels; c++) begin
        acc_q[c]  <= '0;
        ptr_q[c]  <= '0;
        fill_q[c] <= '0;
      end
      win_exp_q     <= '0;
      out_valid_q   <= 1'b0;
      out_channel_q <= '0;
      d_out_q       <= '0;
      out_primed_q  <= 1'b0;
    end else begin
      win_exp_q   <= win_exp;
      out_valid_q <= take;
      if (flush_eff) begin
        for (int c = 0; c < Channels; c++) begin
          acc_q[c]  <= '0;
          ptr_q[c]  <= '0;
          fill_q[c] <= '0;
        end
      end else if (take) begin
        acc_q[idx]    <= acc_d;
        ptr_q[idx]    <= ptr_q[idx] + PtrW'(1);
        fill_q[idx]   <= fill_d;
        out_channel_q <= idx;
        d_out_q       <= d_out_d;
        out_primed_q  <= (fill_d >= n_val);
      end
    end
  end

  assign out_valid   = out_valid_q;
  assign out_channel = out_channel_q;
  assign d_out       = d_out_q;
  assign out_primed  = out_primed_q;

endmodule

// File: tb/tb_moving_average_multichannel.sv
// Testbench for moving_average_multichannel: an unsigned and a signed instance
// (3 channels, so channel index 3 is out of range) share all inputs and are
// checked every cycle against a window-history reference model.

module tb_moving_average_multichannel;

  localparam int ME = 4;
  localparam int DW = 16;
  localparam int CH = 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic          flush = 1'b0;
  logic [2:0]    win_exp = '0;
  logic          in_valid = 1'b0;
  logic [1:0]    in_channel = '0;
  logic [DW-1:0] d_in = '0;

  logic          out_valid_u, out_primed_u, out_valid_s, out_primed_s;
  logic [1:0]    out_channel_u, out_channel_s;
  logic [DW-1:0] d_out_u, d_out_s;

  moving_average_multichannel #(.MaxExponent(ME), .DataWidth(DW), .Channels(CH), .Signed(0)) u_dut_u (
    .clk(clk), .reset(reset), .flush(flush), .win_exp(win_exp), .in_valid(in_valid),
    .in_channel(in_channel), .d_in(d_in), .out_valid(out_valid_u),
    .out_channel(out_channel_u), .d_out(d_out_u), .out_primed(out_primed_u));

  moving_average_multichannel #(.MaxExponent(ME), .DataWidth(DW), .Channels(CH), .Signed(1)) u_dut_s (
    .clk(clk), .reset(reset), .flush(flush), .win_exp(win_exp), .in_valid(in_valid),
    .in_channel(in_channel), .d_in(d_in), .out_valid(out_valid_s),
    .out_channel(out_channel_s), .d_out(d_out_s), .out_primed(out_primed_s));

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad = 0;

  // {channel[2], primed[1], d_signed[16], d_unsigned[16]}
  logic [34:0]   exp_q[$];
  logic [DW-1:0] hist[CH][$];
  logic [2:0]    prev_we = '0;
  logic          exp_v;
  logic [DW-1:0] last_du, last_ds;
  logic          last_pu;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Average of the newest 2^e samples, missing ones counted as zero.
  function automatic logic [DW-1:0] model_avg(input int c, input int e, input bit sgn);
    longint sum;
    logic [DW-1:0] x;
    int n;
    int sz;
    sum = 0;
    n = 1 << e;
    sz = hist[c].size();
    for (int k = 0; k < n && k < sz; k++) begin
      x = hist[c][sz-1-k];
      sum += sgn ? longint'($signed(x)) : longint'({48'b0, x});
    end
`ifdef MOVING_AVERAGE_ROUNDING_EN
    if (e > 0) sum += longint'(1) << (e - 1);
`endif
    sum = sum >>> e;
    return sum[DW-1:0];
  endfunction

  task automatic model_clear();
    for (int c = 0; c < CH; c++) hist[c].delete();
  endtask

  task automatic model_apply(input logic fl, input logic [2:0] we, input logic v,
                             input logic [1:0] ch, input logic [DW-1:0] d);
    int e;
    logic [DW-1:0] du, ds;
    logic pr;
    e = (we > 3'(ME)) ? ME : int'(we);
    exp_v = 1'b0;
    if (fl || we != prev_we) begin
      model_clear();
    end else if (v && int'(ch) < CH) begin
      hist[ch].push_back(d);
      if (hist[ch].size() > (1 << ME)) void'(hist[ch].pop_front());
      du = model_avg(int'(ch), e, 1'b0);
      ds = model_avg(int'(ch), e, 1'b1);
      pr = hist[ch].size() >= (1 << e);
      exp_q.push_back({ch, pr, ds, du});
      exp_v = 1'b1;
    end
    prev_we = we;
  endtask

  // ---------------- driver ----------------
  // Called at posedge+1; applies one cycle of inputs and checks the result.
  task automatic step(input logic fl, input logic [2:0] we, input logic v,
                      input logic [1:0] ch, input logic [DW-1:0] d);
    logic [34:0] ex;
    flush = fl; win_exp = we; in_valid = v; in_channel = ch; d_in = d;
    model_apply(fl, we, v, ch, d);
    @(posedge clk); #1;
    check("valid_u", 32'(out_valid_u), 32'(exp_v));
    check("valid_s", 32'(out_valid_s), 32'(exp_v));
    if (exp_v && exp_q.size() > 0) begin
      ex = exp_q.pop_front();
      check("chan_u",   32'(out_channel_u), 32'(ex[34:33]));
      check("chan_s",   32'(out_channel_s), 32'(ex[34:33]));
      check("primed_u", 32'(out_primed_u),  32'(ex[32]));
      check("primed_s", 32'(out_primed_s),  32'(ex[32]));
      check("dout_u",   32'(d_out_u),       32'(ex[15:0]));
      check("dout_s",   32'(d_out_s),       32'(ex[31:16]));
    end
    last_du = d_out_u; last_ds = d_out_s; last_pu = out_primed_u;
    flush = 1'b0; in_valid = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid_u"},  32'(out_valid_u),   0);
    check({tag, "_valid_s"},  32'(out_valid_s),   0);
    check({tag, "_dout_u"},   32'(d_out_u),       0);
    check({tag, "_chan_u"},   32'(out_channel_u), 0);
    check({tag, "_primed_u"}, 32'(out_primed_u),  0);
  endtask

  // Asserts reset right after an edge, so any pending result must vanish at once.
  task automatic do_reset();
    reset = 1'b1;
    #1;
    check_reset_outputs("rst_mid");
    model_clear();
    exp_q.delete();
    prev_we = '0;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  int r34_d[5] = '{1, 3, 6, 10, 14};
  int r34_p[5] = '{0, 0, 0, 1, 1};

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    reset = 1'b0;

    // Ramp on ch0, N=4
    step(0, 3'd2, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      step(0, 3'd2, 1, 0, 16'(4 * (i + 1)));
      check("ramp_dout", 32'(last_du), 32'(r34_d[i]));
      check("ramp_primed", 32'(last_pu), 32'(r34_p[i]));
    end

    // Window change re-flushes; then flush together with a sample
    step(0, 3'd3, 0, 0, 0);
    step(0, 3'd3, 1, 0, 16'd80);
    check("wchg_dout", 32'(last_du), 10);
    check("wchg_primed", 32'(last_pu), 0);
    step(1, 3'd3, 1, 0, 16'd55);
    check("flush_drop", 32'(out_valid_u), 0);

    // Signed negatives, N=2
    step(0, 3'd1, 0, 0, 0);
    step(0, 3'd1, 1, 1, 16'hFFFD);
`ifdef MOVING_AVERAGE_ROUNDING_EN
    check("neg_first", 32'(last_ds), 32'h0000FFFF);
`else
    check("neg_first", 32'(last_ds), 32'h0000FFFE);
`endif
    step(0, 3'd1, 1, 1, 16'hFFFB);
    check("neg_second", 32'(last_ds), 32'h0000FFFC);

    // Interleaved channels, N=8
    step(0, 3'd3, 0, 0, 0);
    for (int i = 0; i < 16; i++) begin
      if (i % 2 == 0) step(0, 3'd3, 1, 0, 16'd100);
      else            step(0, 3'd3, 1, 2, 16'd200);
      if (i == 14) check("ilv_ch0", 32'(last_du), 100);
      if (i == 15) check("ilv_ch2", 32'(last_du), 200);
    end

    // Out-of-range channel is ignored
    step(0, 3'd3, 1, 2'd3, 16'hFFFF);
    check("oor_valid", 32'(out_valid_u), 0);
    step(0, 3'd3, 1, 0, 16'd100);
    check("oor_after", 32'(last_du), 100);

    // Reset in flight, then a fresh sample
    step(0, 3'd2, 0, 0, 0);
    step(0, 3'd2, 1, 0, 16'd50);
    do_reset();
    step(0, 3'd2, 0, 0, 0);
    step(0, 3'd2, 1, 0, 16'd16);
    check("post_reset", 32'(last_du), 4);

    // Random traffic including clamped exponents, flushes and bad channels
    begin
      logic [2:0] we;
      we = 3'd3;
      for (int i = 0; i < 600; i++) begin
        if (i == 300) do_reset();
        if ($urandom_range(0, 39) == 0) we = 3'($urandom_range(0, 7));
        step(($urandom_range(0, 29) == 0), we, ($urandom_range(0, 3) != 0),
             2'($urandom_range(0, 3)), 16'($urandom));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/moving_average_multichannel.md
MOVING_AVERAGE_MULTICHANNEL -- requirements
Module: moving_average_multichannel

Interface
REQ-001 SHALL have parameter MaxExponent, default 4: maximum window 2^MaxExponent samples per channel.
REQ-002 SHALL have parameter DataWidth, default 16: sample and output width.
REQ-003 SHALL have parameter Channels, default 4: number of independent channels, time-multiplexed on one input.
REQ-004 SHALL have parameter Signed, default 0: 1 means samples are two's complement; 0 means unsigned.
REQ-005 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-006 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-007 SHALL have port flush, input, 1: synchronous clear of all channel state.
REQ-008 SHALL have port win_exp, input, $clog2(MaxExponent+1): runtime window exponent e, where window N = 2^e.
REQ-009 SHALL have port in_valid, input, 1: sample strobe.
REQ-010 SHALL have port in_channel, input, $clog2(Channels) (minimum 1): channel of d_in.
REQ-011 SHALL have port d_in, input, DataWidth: sample.
REQ-012 SHALL have port out_valid, output, 1: result strobe.
REQ-013 SHALL have port out_channel, output, $clog2(Channels) (minimum 1): channel of d_out.
REQ-014 SHALL have port d_out, output, DataWidth: window average.
REQ-015 SHALL have port out_primed, output, 1: the window of out_channel held N samples when d_out was computed.

Function
REQ-016 SHALL keep, per channel: a circular buffer of 2^MaxExponent samples, a write pointer, a fill count saturating at N, and an accumulator of DataWidth+MaxExponent bits (sign-extended when Signed=1).
REQ-017 On in_valid with in_channel < Channels: acc_new = acc + d_in - old, where old = buffer[(ptr - N) mod 2^MaxExponent] if fill ≥ N, else 0.
REQ-018 On that same cycle: write d_in at ptr, advance ptr modulo 2^MaxExponent, increment fill saturating at N.
REQ-019 Latency SHALL be exactly 1 cycle: out_valid, out_channel and d_out are registered on the edge after in_valid; out_valid is low otherwise.
REQ-020 d_out SHALL be acc_new >> e (arithmetic shift when Signed=1), truncated to DataWidth; the average includes the current sample.
REQ-021 Before the window is primed, the output SHALL still divide by N (zero-filled window), and out_primed=0.
REQ-022 Samples with in_channel ≥ Channels SHALL be ignored: no state change and out_valid=0.
REQ-023 win_exp > MaxExponent SHALL be treated as MaxExponent.
REQ-024 A change of win_exp from the previous cycle's registered value SHALL act as a flush in that cycle.
REQ-025 flush SHALL zero every accumulator, pointer and fill count; the buffer contents need not be cleared.
REQ-026 flush and in_valid together: the flush wins, the sample is dropped, and out_valid=0 next cycle.
REQ-027 Back-to-back samples on the same channel on consecutive cycles SHALL be supported at full rate with correct results.
REQ-028 Accumulators SHALL never overflow: |sum of 2^MaxExponent samples| fits in DataWidth+MaxExponent bits.

Reset
REQ-029 reset SHALL asynchronously clear out_valid, out_channel, d_out, out_primed, all accumulators, pointers, fill counts and the registered win_exp to 0.
REQ-030 reset asserted mid-stream SHALL discard any in-flight result; the first output after release reflects only post-reset samples.

Configuration
REQ-031 Macro MOVING_AVERAGE_ROUNDING_EN defined: d_out = (acc_new + 2^(e-1)) >> e for e > 0, i.e. round half up toward +infinity; e = 0 is unchanged.
REQ-032 Macro MOVING_AVERAGE_ROUNDING_EN undefined: d_out = acc_new >> e, i.e. floor.
REQ-033 Rounding SHALL NOT change latency or port list.

Verification
REQ-034 Unsigned, e=2, ch0 fed 4,8,12,16,20 -> d_out 1,3,6,10,14; out_primed 0,0,0,1,1.
REQ-035 Signed=1, e=1, ch1 fed -3,-5 -> floor gives -2,-4; with MOVING_AVERAGE_ROUNDING_EN gives -1,-4.
REQ-036 Interleave ch0=100 and ch2=200 each cycle, e=3, 16 cycles -> each channel's d_out reaches 100 and 200 respectively at its 8th sample, with no cross-talk.
REQ-037 win_exp changed 2→3 after ch0 is primed -> next ch0 sample 80 gives d_out 10 with out_primed=0; flush together with in_valid -> out_valid=0.
REQ-038 reset asserted the cycle after in_valid -> out_valid=0 immediately; first post-reset sample 16, e=2 -> d_out 4.
REQ-039 in_channel=Channels (out of range) with d_in=0xFFFF -> out_valid=0 and later results unaffected.
